// File: rtl/rv32i_data_memory.sv
// RV32I data-memory responder: byte-lane RAM plus a small MMIO window (console TX, status, cycles, error address).
// Optional cycle counter is built only when DM_CYCLE_COUNTER_EN is defined; otherwise CYCLES reads 0.
module rv32i_data_memory #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [15:0] MMIO_PAGE   = 16'hFFFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dmAddress,
   input  logic [2:0]  dmFunc3,
   input  logic        dmWrite,
   input  logic [31:0] dmDataOut,
   output logic [31:0] dmDataIn,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic          is_mmio;
   logic [AW-1:0] widx;
   logic [31:0]   rd_word;
   logic [1:0]    mmio_off;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          st_bad, ram_we, store_err, tx_accept;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   load_val, mmio_rd, cycles_rd;
   logic          unused_addr;

   logic [31:0] dm_data_in_q, dm_data_in_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        err_flag_q, err_flag_d;
   logic        overrun_flag_q, overrun_flag_d;
   logic [31:0] err_addr_q, err_addr_d;

   assign is_mmio     = (dmAddress[31:16] == MMIO_PAGE);
   assign widx        = dmAddress[AW+1:2];
   assign mmio_off    = dmAddress[3:2];
   assign rd_word     = mem[widx];
   assign unused_addr = ^dmAddress;

`ifdef DM_CYCLE_COUNTER_EN
   logic [31:0] cycle_count_q, cycle_count_d;
   assign cycle_count_d = cycle_count_q + 32'd1;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cycle_count_q <= '0;
      else        cycle_count_q <= cycle_count_d;
   end
   assign cycles_rd = cycle_count_q;
`else
   assign cycles_rd = '0;
`endif

   // Store lane enables; data is replicated across lanes so only be[] selects.
   always_comb begin
      be     = 4'b0000;
      wdata  = dmDataOut;
      st_bad = 1'b0;
      case (dmFunc3)
         3'd0: begin
            be    = 4'b0001 << dmAddress[1:0];
            wdata = {4{dmDataOut[7:0]}};
         end
         3'd1: begin
            wdata = {2{dmDataOut[15:0]}};
            if (dmAddress[0]) st_bad = 1'b1;
            else              be = dmAddress[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            if (dmAddress[1:0] != 2'b00) st_bad = 1'b1;
            else                         be = 4'b1111;
         end
         default: st_bad = 1'b1;
      endcase
   end

   assign ram_we    = dmWrite && !is_mmio && !st_bad;
   assign store_err = dmWrite && !is_mmio && st_bad;

   always_ff @(posedge clock) begin
      for (int b = 0; b < 4; b++)
         if (ram_we && be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
   end

   always_comb begin
      ld_byte = rd_word[8*dmAddress[1:0] +: 8];
      ld_half = dmAddress[1] ? rd_word[31:16] : rd_word[15:0];
      case (dmFunc3)
         3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
         3'd4:    load_val = {24'b0, ld_byte};
         3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
         3'd5:    load_val = {16'b0, ld_half};
         default: load_val = rd_word;
      endcase
   end

   always_comb begin
      case (mmio_off)
         2'd0:    mmio_rd = {24'b0, tx_data_q};
         2'd1:    mmio_rd = {29'b0, overrun_flag_q, err_flag_q, tx_valid_q};
         2'd2:    mmio_rd = cycles_rd;
         default: mmio_rd = err_addr_q;
      endcase
   end

   assign tx_accept = tx_valid_q && txReady;

   always_comb begin
      tx_data_d      = tx_data_q;
      tx_valid_d     = tx_valid_q;
      err_flag_d     = err_flag_q;
      overrun_flag_d = overrun_flag_q;
      err_addr_d     = err_addr_q;
      dm_data_in_d   = dm_data_in_q;
      if (tx_accept) tx_valid_d = 1'b0;
      if (dmWrite && is_mmio) begin
         case (mmio_off)
            2'd0: begin
               if (!tx_valid_q || txReady) begin
                  tx_data_d  = dmDataOut[7:0];
                  tx_valid_d = 1'b1;
               end else begin
                  overrun_flag_d = 1'b1;
               end
            end
            2'd1: begin
               if (dmDataOut[1]) err_flag_d     = 1'b0;
               if (dmDataOut[2]) overrun_flag_d = 1'b0;
            end
            default: ;
         endcase
      end
      // Applied after the clears so a simultaneous new error wins.
      if (store_err) begin
         err_flag_d = 1'b1;
         if (!err_flag_q) err_addr_d = dmAddress;
      end
      if (!dmWrite) dm_data_in_d = is_mmio ? mmio_rd : load_val;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dm_data_in_q   <= '0;
         tx_data_q      <= '0;
         tx_valid_q     <= 1'b0;
         err_flag_q     <= 1'b0;
         overrun_flag_q <= 1'b0;
         err_addr_q     <= '0;
      end else begin
         dm_data_in_q   <= dm_data_in_d;
         tx_data_q      <= tx_data_d;
         tx_valid_q     <= tx_valid_d;
         err_flag_q     <= err_flag_d;
         overrun_flag_q <= overrun_flag_d;
         err_addr_q     <= err_addr_d;
      end
   end

   assign dmDataIn = dm_data_in_q;
   assign txData   = tx_data_q;
   assign txValid  = tx_valid_q;
endmodule

// File: doc/rv32i_data_memory.md
Name: rv32i_data_memory

Overview:
- Responder end of the RV32I data-memory port: services dmAddress/dmFunc3/dmWrite/dmDataOut from the core and returns dmDataIn with 1-cycle registered latency, which matches the core's single load bubble.
- Handles byte/half/word stores with lane merge, and load sign/zero extension.
- Decodes a small MMIO window holding a console transmit register with valid/ready handshake, a status/error register and a cycle counter.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- MMIO_PAGE, 16'hFFFF, value of dmAddress[31:16] that selects the MMIO window.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- dmAddress  input  32  byte address from core.
- dmFunc3  input  3  access size/sign (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
- dmWrite  input  1  store strobe, sampled at posedge.
- dmDataOut  input  32  store data from core.
- dmDataIn  output  32  registered load data to core.
- txData  output  8  console byte.
- txValid  output  1  console byte pending.
- txReady  input  1  console sink accepts byte at posedge when txValid=1.

Behaviour:
- Reset (reset=0, async): dmDataIn=0, txValid=0, txData=0, errFlag=0, overrunFlag=0, errAddr=0, cycleCount=0. RAM contents are not reset.
- RAM decode: word index = dmAddress[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored (aliasing/wrap) unless dmAddress[31:16]==MMIO_PAGE.
- Store (dmWrite=1, RAM region), written at posedge:
  - SB: lane dmAddress[1:0] <= dmDataOut[7:0].
  - SH: lanes {addr[1],0}..{addr[1],1} <= dmDataOut[15:0].
  - SW: all four lanes.
- Store errors: SH with addr[0]=1, SW with addr[1:0]!=0, or func3 not in {0,1,2} causes no write, errFlag<=1, and errAddr<=dmAddress only if errFlag was 0 (first error captured).
- Read (dmWrite=0): every posedge, dmDataIn <= extend(selected word).
  - LB/LBU: byte at addr[1:0], sign/zero extended.
  - LH/LHU: half at addr[1], sign/zero extended; addr[0] is ignored.
  - LW: full word; addr[1:0] is ignored.
  - func3 3/6/7: full word.
  - Reads never set errors, because the core drives func3 of arbitrary instructions when idle.
- Write cycle: dmDataIn holds its previous value.
- Back-to-back: a store followed by a load to the same address on the next cycle returns the new data (write committed at the first posedge, read at the second).
- MMIO window (dmAddress[31:16]==MMIO_PAGE, offset = dmAddress[3:2]; RAM untouched):
  - 0 TXDATA:
    - Write: if txValid=0, or txValid=1 and txReady=1 this cycle, then txData<=dmDataOut[7:0] and txValid<=1.
    - Write otherwise: byte dropped, overrunFlag<=1.
    - Read: {24'b0,txData}.
  - 1 STATUS:
    - Read: {29'b0, overrunFlag, errFlag, txValid}.
    - Write: bit1=1 clears errFlag; bit2=1 clears overrunFlag. If a clear coincides with a new error in the same cycle, the new error wins.
  - 2 CYCLES: read cycleCount; writes ignored.
  - 3 ERRADDR: read errAddr; writes ignored.
  - MMIO accesses are not checked for size/alignment. Reads return the full 32-bit register regardless of func3.
- Console handshake: when txValid=1 and txReady=1 at posedge, txValid<=0 unless a TXDATA write reloads it in the same cycle. txData is stable while txValid=1 and not accepted.
- cycleCount: increments every posedge out of reset; wraps 32'hFFFFFFFF -> 0.
- Reset mid-transfer: txValid drops immediately (async); a pending byte is lost.

Optional Feature:
- Macro: DM_CYCLE_COUNTER_EN.
- Defined: cycleCount is implemented as above.
- Undefined: no counter register is synthesized; CYCLES reads 0.

Test Plan:
- SW 0x12345678 @0x40, then LB @0x41 / LBU @0x43 / LH @0x42 / LW @0x40 -> dmDataIn one cycle later = 0x00000056, 0x00000012, 0x00001234, 0x12345678; SB 0x80 @0x44 then LB @0x44 -> 0xFFFFFF80, LBU -> 0x00000080.
- SH 0xBEEF @0x42 over word 0x11223344 @0x40 -> LW @0x40 = 0xBEEF3344; SB 0xAA @0x40 -> 0xBEEF33AA.
- SW @0x46 (misaligned) then SH @0x51 -> memory unchanged, STATUS bit1=1, ERRADDR=0x00000046; write STATUS 0x2 -> bit1=0.
- txReady=0, write TXDATA 0x41 then 0x42 -> txValid=1, txData=0x41, STATUS=0x5. Raise txReady one cycle -> txValid=0. Write 0x43 with txReady=1 during a pending byte -> txData=0x43, txValid stays 1.
- Pulse reset low mid-operation with txValid=1, errFlag=1 -> all outputs 0 immediately. Write SW to @0x1000+0x40 with DEPTH_WORDS=1024 -> aliases to 0x40.
- With DM_CYCLE_COUNTER_EN: two CYCLES reads 10 cycles apart differ by 10. Without it: CYCLES reads 0.
